rgbled_chain_ctrl: RTL and testbench

RGBLED_CHAIN_CTRL -- requirements
Module: rgbled_chain_ctrl

---
 rtl/rgbled_chain_ctrl.sv | 179 +++++++++++++++++
 tb/tb_rgbled_chain_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgbled_chain_ctrl.sv
// WS281x LED chain driver: flop frame buffer, MSB-first bit serialiser and latch timer.
// Optional continuous refresh: define RGBLED_AUTO_REFRESH_EN.
`timescale 1ns/1ps

module rgbled_chain_ctrl #(
  parameter int NumLeds     = 2,
  parameter int T0HCycles   = 10,
  parameter int T1HCycles   = 20,
  parameter int BitCycles   = 31,
  parameter int LatchCycles = 2000
) (
  input  logic                                               main_clk_buf,
  input  logic                                               rst_sys_n,
  input  logic                                               wr_en_i,
  input  logic [((NumLeds > 1) ? $clog2(NumLeds) : 1)-1:0]   wr_addr_i,
  input  logic [23:0]                                        wr_data_i,
  input  logic                                               go_i,
  output logic                                               busy_o,
  output logic                                               done_o,
  output logic                                               ws281x_dout_o
);

  localparam int AddrW  = (NumLeds > 1) ? $clog2(NumLeds) : 1;
  localparam int MaxCyc = (BitCycles > LatchCycles) ? BitCycles : LatchCycles;
  localparam int CntW   = $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0]  T0Last    = CntW'(T0HCycles - 1);
  localparam logic [CntW-1:0]  T1Last    = CntW'(T1HCycles - 1);
  localparam logic [CntW-1:0]  L0Last    = CntW'(BitCycles - T0HCycles - 1);
  localparam logic [CntW-1:0]  L1Last    = CntW'(BitCycles - T1HCycles - 1);
  localparam logic [CntW-1:0]  LatchLast = CntW'(LatchCycles - 1);
  localparam logic [CntW-1:0]  LatchPre  = CntW'(LatchCycles - 2);
  localparam logic [AddrW-1:0] LastLed   = AddrW'(NumLeds - 1);

`ifdef RGBLED_AUTO_REFRESH_EN
  localparam bit AutoRefresh = 1'b1;
`else
  localparam bit AutoRefresh = 1'b0;
`endif

  if (NumLeds < 1 || NumLeds > 64) begin : g_chk_num_leds
    $error("rgbled_chain_ctrl: NumLeds must be within 1..64");
  end
  if (T0HCycles < 1 || T0HCycles >= T1HCycles) begin : g_chk_t0h
    $error("rgbled_chain_ctrl: need 1 <= T0HCycles < T1HCycles");
  end
  if (T1HCycles >= BitCycles) begin : g_chk_t1h
    $error("rgbled_chain_ctrl: need T1HCycles < BitCycles");
  end
  if (LatchCycles < 2) begin : g_chk_latch
    $error("rgbled_chain_ctrl: LatchCycles must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } state_t;

  // Frame buffer: one register per LED; out-of-range addresses match no entry.
  logic [23:0] fb_q [NumLeds];

  genvar gi;
  generate
    for (gi = 0; gi < NumLeds; gi++) begin : g_fb
      logic [23:0] entry_reg;
      always_ff @(posedge main_clk_buf or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
          entry_reg <= '0;
        end else if (wr_en_i && (wr_addr_i == AddrW'(gi))) begin
          entry_reg <= wr_data_i;
        end
      end
      assign fb_q[gi] = entry_reg;
    end
  endgenerate

  state_t            state_reg;
  logic [CntW-1:0]   cnt_reg;
  logic [4:0]        bit_idx_reg;
  logic [AddrW-1:0]  led_idx_reg;
  logic [23:0]       shift_reg;
  logic              dout_reg;
  logic              busy_reg;
  logic              done_reg;

  // shift_reg[23] is the bit currently on the wire in HIGH and LOW.
  logic [CntW-1:0] high_last;
  logic [CntW-1:0] low_last;
  assign high_last = shift_reg[23] ? T1Last : T0Last;
  assign low_last  = shift_reg[23] ? L1Last : L0Last;

  always_ff @(posedge main_clk_buf or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      led_idx_reg <= '0;
      shift_reg   <= '0;
      dout_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          dout_reg <= 1'b0;
          cnt_reg  <= '0;
          if (go_i || AutoRefresh) begin
            state_reg   <= ST_LOAD;
            busy_reg    <= 1'b1;
            led_idx_reg <= '0;
          end
        end
        ST_LOAD: begin
          // Registered buffer read: a write landing this cycle is seen next frame.
          shift_reg   <= fb_q[led_idx_reg];
          bit_idx_reg <= '0;
          cnt_reg     <= '0;
          dout_reg    <= 1'b1;
          state_reg   <= ST_HIGH;
        end
        ST_HIGH: begin
          if (cnt_reg == high_last) begin
            cnt_reg   <= '0;
            dout_reg  <= 1'b0;
            state_reg <= ST_LOW;
          end else begin
            cnt_reg <= cnt_reg + CntW'(1);
          end
        end
        ST_LOW: begin
          if (cnt_reg == low_last) begin
            cnt_reg <= '0;
            if (bit_idx_reg == 5'd23) begin
              if (led_idx_reg == LastLed) begin
                state_reg <= ST_LATCH;
              end else begin
                led_idx_reg <= led_idx_reg + AddrW'(1);
                state_reg   <= ST_LOAD;
              end
            end else begin
              bit_idx_reg <= bit_idx_reg + 5'd1;
              shift_reg   <= {shift_reg[22:0], 1'b0};
              dout_reg    <= 1'b1;
              state_reg   <= ST_HIGH;
            end
          end else begin
            cnt_reg <= cnt_reg + CntW'(1);
          end
        end
        ST_LATCH: begin
          // done_reg is raised one cycle early so it coincides with the final latch cycle.
          if (cnt_reg == LatchLast) begin
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg  <= cnt_reg + CntW'(1);
            done_reg <= (cnt_reg == LatchPre);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          dout_reg  <= 1'b0;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign busy_o        = busy_reg;
  assign done_o        = done_reg;
  assign ws281x_dout_o = dout_reg;

endmodule

// File: tb/tb_rgbled_chain_ctrl.sv
// Directed bench for rgbled_chain_ctrl: frame timing, buffer writes, reset abort, refresh mode.
`timescale 1ns/1ps

module tb_rgbled_chain_ctrl;

  `define CHECK(tag, obs, exp) \
    begin \
      n_checks++; \
      assert ((obs) === (exp)) else begin \
        n_err++; \
        $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
      end \
    end

  int n_checks = 0;
  int n_err    = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst1_n;

  // Instance A: default parameters, two LEDs.
  logic        wr_en_a, go_a;
  logic [0:0]  wr_addr_a;
  logic [23:0] wr_data_a;
  logic        busy_a, done_a, dout_a;

  // Instance 3: three LEDs with short timing.
  logic        wr_en_3, go_3;
  logic [1:0]  wr_addr_3;
  logic [23:0] wr_data_3;
  logic        busy_3, done_3, dout_3;

  // Instance 1: one LED, default timing, never given go.
  logic        wr_en_1, go_1;
  logic [0:0]  wr_addr_1;
  logic [23:0] wr_data_1;
  logic        busy_1, done_1, dout_1;

  rgbled_chain_ctrl dut_a (
    .main_clk_buf(clk), .rst_sys_n(rst_n), .wr_en_i(wr_en_a), .wr_addr_i(wr_addr_a),
    .wr_data_i(wr_data_a), .go_i(go_a), .busy_o(busy_a), .done_o(done_a), .ws281x_dout_o(dout_a)
  );

  rgbled_chain_ctrl #(
    .NumLeds(3), .T0HCycles(2), .T1HCycles(4), .BitCycles(7), .LatchCycles(8)
  ) dut_3 (
    .main_clk_buf(clk), .rst_sys_n(rst_n), .wr_en_i(wr_en_3), .wr_addr_i(wr_addr_3),
    .wr_data_i(wr_data_3), .go_i(go_3), .busy_o(busy_3), .done_o(done_3), .ws281x_dout_o(dout_3)
  );

  rgbled_chain_ctrl #(.NumLeds(1)) dut_1 (
    .main_clk_buf(clk), .rst_sys_n(rst1_n), .wr_en_i(wr_en_1), .wr_addr_i(wr_addr_1),
    .wr_data_i(wr_data_1), .go_i(go_1), .busy_o(busy_1), .done_o(done_1), .ws281x_dout_o(dout_1)
  );

  // Monitor the single-LED instance continuously.
  int cyc_cnt = 0;
  int busy1_cnt = 0;
  int done1_cnt = 0;
  int done1_t [4];
  always @(negedge clk) begin
    cyc_cnt++;
    if (busy_1) busy1_cnt++;
    if (done_1) begin
      if (done1_cnt < 4) done1_t[done1_cnt] = cyc_cnt;
      done1_cnt++;
    end
  end

  logic sel3;
  logic m_dout, m_busy, m_done;
  assign m_dout = sel3 ? dout_3 : dout_a;
  assign m_busy = sel3 ? busy_3 : busy_a;
  assign m_done = sel3 ? done_3 : done_a;

  int          hw [72];
  int          lw [72];
  logic [71:0] bits;
  int          np, hi_tot, busy_cnt, done_cnt;
  logic        done_last, timed_out;

  // Sample the selected instance until busy falls; decode bits by high-pulse width.
  task automatic capture(input int thresh, input int limit);
    logic prev;
    logic fin;
    int   cyc;
    int   cur;
    logic seen;
    np = 0; hi_tot = 0; busy_cnt = 0; done_cnt = 0; bits = '0;
    done_last = 1'b0; timed_out = 1'b0;
    prev = 1'b0; fin = 1'b0; cyc = 0; cur = 0; seen = 1'b0;
    for (int i = 0; i < 72; i++) begin
      hw[i] = 0;
      lw[i] = 0;
    end
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (m_busy) begin
        seen = 1'b1;
        busy_cnt++;
        done_last = m_done;
      end
      if (m_done) done_cnt++;
      if (m_dout) begin
        hi_tot++;
        cur++;
      end else if (prev) begin
        if (np < 72) begin
          hw[np] = cur;
          bits = {bits[70:0], (cur > thresh)};
        end
        np++;
        cur = 0;
      end
      if (!m_dout && m_busy && np > 0 && np <= 72) lw[np-1]++;
      prev = m_dout;
      if (seen && !m_busy) fin = 1'b1;
      if (cyc >= limit) begin
        timed_out = 1'b1;
        fin = 1'b1;
      end
    end
  endtask

  task automatic wr_a(input int addr, input logic [23:0] d);
    @(negedge clk);
    wr_en_a = 1'b1; wr_addr_a = 1'(addr); wr_data_a = d;
    @(negedge clk);
    wr_en_a = 1'b0;
  endtask

  task automatic wr_3(input int addr, input logic [23:0] d);
    @(negedge clk);
    wr_en_3 = 1'b1; wr_addr_3 = 2'(addr); wr_data_3 = d;
    @(negedge clk);
    wr_en_3 = 1'b0;
  endtask

  // go is sampled on the following rising edge; the next negedge sees LOAD.
  task automatic pulse_go_a();
    @(negedge clk);
    go_a = 1'b1;
    @(posedge clk);
    #1 go_a = 1'b0;
  endtask

  task automatic pulse_go_3();
    @(negedge clk);
    go_3 = 1'b1;
    @(posedge clk);
    #1 go_3 = 1'b0;
  endtask

  int   bad;
  logic restarted;

  initial begin
    rst_n = 1'b0; rst1_n = 1'b0; sel3 = 1'b0;
    wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0; go_a = 1'b0;
    wr_en_3 = 1'b0; wr_addr_3 = '0; wr_data_3 = '0; go_3 = 1'b0;
    wr_en_1 = 1'b0; wr_addr_1 = '0; wr_data_1 = '0; go_1 = 1'b0;
    repeat (3) @(negedge clk);
    `CHECK("rst_busy", busy_a, 1'b0)
    `CHECK("rst_done", done_a, 1'b0)
    `CHECK("rst_dout", dout_a, 1'b0)
    rst_n = 1'b1; rst1_n = 1'b1;

`ifdef RGBLED_AUTO_REFRESH_EN
    @(negedge clk);
    `CHECK("auto_start_busy", busy_a, 1'b1)
    for (int i = 0; i < 10000 && done1_cnt < 3; i++) @(negedge clk);
    `CHECK("auto_three_frames", (done1_cnt >= 3), 1'b1)
    `CHECK("auto_period_1", done1_t[1] - done1_t[0], 24 * 31 + 2000 + 2)
    `CHECK("auto_period_2", done1_t[2] - done1_t[1], 24 * 31 + 2000 + 2)
`else
    repeat (2) @(negedge clk);
    `CHECK("idle_after_release", busy_a, 1'b0)

    // Three-LED instance; address 3 is outside the buffer and must be dropped.
    sel3 = 1'b1;
    wr_3(0, 24'hA5A5A5);
    wr_3(1, 24'h0F0F0F);
    wr_3(2, 24'h123456);
    wr_3(3, 24'hFFFFFF);
    pulse_go_3();
    capture(2, 2000);
    `CHECK("n3_timeout", timed_out, 1'b0)
    `CHECK("n3_bits", bits, 72'hA5A5A5_0F0F0F_123456)
    `CHECK("n3_busy_cycles", busy_cnt, 3 * (24 * 7 + 1) + 8)
    `CHECK("n3_done_count", done_cnt, 1)
    `CHECK("n3_done_at_end", done_last, 1'b1)
    sel3 = 1'b0;

    // LED0 = 800000, LED1 = 0.
    wr_a(0, 24'h800000);
    wr_a(1, 24'h000000);
    pulse_go_a();
    capture(10, 5000);
    `CHECK("f1_timeout", timed_out, 1'b0)
    `CHECK("f1_first_high", hw[0], 20)
    `CHECK("f1_first_low", lw[0], 11)
    `CHECK("f1_bit1_high", hw[1], 10)
    `CHECK("f1_bit1_low", lw[1], 21)
    `CHECK("f1_bit23_high", hw[23], 10)
    `CHECK("f1_bit23_low_plus_load", lw[23], 22)
    `CHECK("f1_led1_bit0_high", hw[24], 10)
    `CHECK("f1_bits", bits[47:0], 48'h800000_000000)
    `CHECK("f1_pulses", np, 48)
    `CHECK("f1_high_total", hi_tot, 20 + 47 * 10)
    `CHECK("f1_busy_cycles", busy_cnt, 2 * (24 * 31 + 1) + 2000)
    `CHECK("f1_done_count", done_cnt, 1)
    `CHECK("f1_done_at_end", done_last, 1'b1)

    // go held high: one frame, one idle cycle, then a fresh frame.
    @(negedge clk);
    go_a = 1'b1;
    capture(10, 5000);
    `CHECK("hold_timeout", timed_out, 1'b0)
    `CHECK("hold_done_count", done_cnt, 1)
    `CHECK("hold_busy_cycles", busy_cnt, 2 * (24 * 31 + 1) + 2000)
    @(negedge clk);
    `CHECK("hold_restart", busy_a, 1'b1)
    go_a = 1'b0;
    capture(10, 5000);
    `CHECK("hold2_done_count", done_cnt, 1)
    `CHECK("hold2_busy_cycles", busy_cnt, 2 * (24 * 31 + 1) + 2000 - 1)
    repeat (20) @(negedge clk);
    `CHECK("hold_stays_idle", busy_a, 1'b0)

    // Writes during LED0: LED1 change lands now, LED0 change next frame.
    pulse_go_a();
    fork
      capture(10, 5000);
      begin
        repeat (100) @(negedge clk);
        wr_a(1, 24'hFFFFFF);
        wr_a(0, 24'h000001);
      end
    join
    `CHECK("mid_bits", bits[47:0], 48'h800000_FFFFFF)
    `CHECK("mid_high_total", hi_tot, 20 + 23 * 10 + 24 * 20)
    pulse_go_a();
    capture(10, 5000);
    `CHECK("next_bits", bits[47:0], 48'h000001_FFFFFF)

    // Reset in the middle of LED0 bit 10.
    pulse_go_a();
    repeat (2 + 310 + 5) @(negedge clk);
    `CHECK("pre_abort_busy", busy_a, 1'b1)
    `CHECK("pre_abort_dout", dout_a, 1'b1)
    #2 rst_n = 1'b0;
    #1;
    `CHECK("abort_dout", dout_a, 1'b0)
    `CHECK("abort_busy", busy_a, 1'b0)
    `CHECK("abort_done", done_a, 1'b0)
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy_a || done_a) bad++;
    end
    `CHECK("abort_no_activity", bad, 0)

    // Buffer cleared by reset: all-zero frame.
    pulse_go_a();
    capture(10, 5000);
    `CHECK("zero_timeout", timed_out, 1'b0)
    `CHECK("zero_bits", bits[47:0], 48'h0)
    `CHECK("zero_high_total", hi_tot, 48 * 10)
    `CHECK("zero_latch_low", lw[47], 21 + 2000)
    `CHECK("zero_busy_cycles", busy_cnt, 2 * (24 * 31 + 1) + 2000)
    `CHECK("zero_done_count", done_cnt, 1)

    // Without go the single-LED instance never left IDLE.
    `CHECK("n1_never_busy", busy1_cnt, 0)
    `CHECK("n1_never_done", done1_cnt, 0)
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
